// File: rtl/scan7seg_if.sv
// Bus between the mm:ss counter stages and the 7-segment scan driver:
// BCD time and display options in, segment, decimal point and digit drive out.
interface scan7seg_if;
   logic [6:0] q_lo;
   logic [6:0] q_hi;
   logic       blank_lz;
   logic       colon;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] dig;

   modport master (
      output q_lo, q_hi, blank_lz, colon,
      input  seg, dp, dig
   );

   modport slave (
      input  q_lo, q_hi, blank_lz, colon,
      output seg, dp, dig
   );
endinterface

// File: rtl/scan7seg.sv
// Four-digit multiplexed 7-segment driver for an mm:ss clock. The BCD inputs are
// snapshotted once per scan frame, and each digit is lit for DIV cycles.
module scan7seg #(
   parameter int unsigned DIV = 1000
) (
   input  logic       clk,
   input  logic       rst,
   scan7seg_if.slave  bus
);
   localparam int unsigned CW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] div_cnt;
   logic          tick_c;
   logic [1:0]    idx;
   logic [13:0]   snap;

   logic [3:0]    nib_c;
   logic          bad_c;
   logic          blank_c;
   logic [6:0]    seg_d_c;
   logic          dp_d_c;

   logic [6:0]    seg_q;
   logic          dp_q;
   logic [3:0]    dig_q;

   function automatic logic [6:0] bcd2seg(input logic [3:0] n);
      case (n)
         4'd0:    bcd2seg = 7'h3F;
         4'd1:    bcd2seg = 7'h06;
         4'd2:    bcd2seg = 7'h5B;
         4'd3:    bcd2seg = 7'h4F;
         4'd4:    bcd2seg = 7'h66;
         4'd5:    bcd2seg = 7'h6D;
         4'd6:    bcd2seg = 7'h7D;
         4'd7:    bcd2seg = 7'h07;
         4'd8:    bcd2seg = 7'h7F;
         4'd9:    bcd2seg = 7'h6F;
         default: bcd2seg = 7'h40;
      endcase
   endfunction

   assign tick_c = (div_cnt == LAST);

   // Prescaler, digit index, and frame snapshot taken as idx wraps 3 -> 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         idx     <= 2'd0;
         snap    <= 14'd0;
      end else begin
         div_cnt <= tick_c ? '0 : div_cnt + CW'(1);
         if (tick_c) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) snap <= {bus.q_hi, bus.q_lo};
         end
      end
   end

   // Select the current digit, validate it, and work out leading-zero blanking
   always_comb begin
      nib_c   = 4'd0;
      bad_c   = 1'b0;
      blank_c = 1'b0;
      case (idx)
         2'd0: begin
            nib_c = snap[3:0];
            bad_c = (snap[3:0] > 4'd9);
         end
         2'd1: begin
            nib_c = {1'b0, snap[6:4]};
            bad_c = (snap[6:4] > 3'd5);
         end
         2'd2: begin
            nib_c   = snap[10:7];
            bad_c   = (snap[10:7] > 4'd9);
            blank_c = bus.blank_lz && (snap[13:11] == 3'd0) && (snap[10:7] == 4'd0);
         end
         2'd3: begin
            nib_c   = {1'b0, snap[13:11]};
            bad_c   = (snap[13:11] > 3'd5);
            blank_c = bus.blank_lz && (snap[13:11] == 3'd0);
         end
         default: ;
      endcase
   end

   // An invalid digit shows '-' even when it would otherwise be blanked
   always_comb begin
      seg_d_c = bcd2seg(nib_c);
      if (bad_c)
         seg_d_c = 7'h40;
      else if (blank_c)
         seg_d_c = 7'h00;
      dp_d_c = (idx == 2'd2) && bus.colon;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_q <= 7'h00;
         dp_q  <= 1'b0;
         dig_q <= 4'hF;
      end else begin
         seg_q <= seg_d_c;
         dp_q  <= dp_d_c;
         dig_q <= ~(4'b0001 << idx);
      end
   end

   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;
   assign bus.dig = dig_q;
endmodule

// File: tb/tb_scan7seg.sv
// Bench for scan7seg: a frame-level reference model checked every cycle, plus
// literal expectations for the reset, decode, blanking and invalid-BCD cases.
module tb_scan7seg;
   localparam int unsigned DIV = 4;
   localparam logic [6:0] SEGTBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic clk = 1'b1;
   logic rst;
   scan7seg_if bus ();

   scan7seg #(.DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;
   int t = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Expected segments of digit d for a captured {q_hi,q_lo} frame
   function automatic logic [6:0] model_seg(input int d, input logic [13:0] s, input logic blz);
      int ones_lo, tens_lo, ones_hi, tens_hi, v;
      bit bad;
      ones_lo = int'(s[3:0]);
      tens_lo = int'(s[6:4]);
      ones_hi = int'(s[10:7]);
      tens_hi = int'(s[13:11]);
      case (d)
         0:       begin v = ones_lo; bad = (v > 9); end
         1:       begin v = tens_lo; bad = (v > 5); end
         2:       begin v = ones_hi; bad = (v > 9); end
         default: begin v = tens_hi; bad = (v > 5); end
      endcase
      if (bad) return 7'h40;
      if (blz && d == 3 && tens_hi == 0) return 7'h00;
      if (blz && d == 2 && tens_hi == 0 && ones_hi == 0) return 7'h00;
      return SEGTBL[v];
   endfunction

   // Reference: edge count since reset release decides the digit; every 4*DIV edges a frame is captured
   int          mk = 0;
   logic [13:0] msnap = 14'd0;
   logic [6:0]  eseg = 7'h00;
   logic        edp = 1'b0;
   logic [3:0]  edig = 4'hF;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mk    = 0;
         msnap = 14'd0;
         eseg  = 7'h00;
         edp   = 1'b0;
         edig  = 4'hF;
      end else begin
         int d;
         mk++;
         d    = ((mk - 1) / int'(DIV)) % 4;
         edig = ~(4'b0001 << d);
         eseg = model_seg(d, msnap, bus.blank_lz);
         edp  = (d == 2) ? bus.colon : 1'b0;
         if (mk % int'(4 * DIV) == 0) msnap = {bus.q_hi, bus.q_lo};
      end
   end

   always @(negedge clk) begin
      if (mon_en) check("mon", 32'({bus.dig, bus.seg, bus.dp}), 32'({edig, eseg, edp}));
   end

   task automatic goto(input int k);
      repeat (k - t) @(negedge clk);
      t = k;
   endtask

   task automatic lit(input string name, input int k, input logic [3:0] dg,
                      input logic [6:0] sg, input logic p);
      goto(k);
      check({name, "_dig"}, 32'(bus.dig), 32'(dg));
      check({name, "_seg"}, 32'(bus.seg), 32'(sg));
      check({name, "_dp"},  32'(bus.dp),  32'(p));
   endtask

   initial begin
      logic [3:0] ones;
      logic [2:0] tens;
      bit found;
      rst          = 1'b0;
      bus.q_lo     = 7'h00;
      bus.q_hi     = 7'h00;
      bus.blank_lz = 1'b0;
      bus.colon    = 1'b0;

      // Reset held across a clock edge
      @(negedge clk);
      @(negedge clk);
      check("rst_dig", 32'(bus.dig), 32'h0000000F);
      check("rst_seg", 32'(bus.seg), 32'h00000000);
      check("rst_dp",  32'(bus.dp),  32'h00000000);
      mon_en   = 1'b1;
      bus.q_hi = 7'h12;
      bus.q_lo = 7'h34;
      bus.colon = 1'b1;
      rst      = 1'b1;
      t        = 0;

      // First frame shows snap = 0, digits step with a 4-cycle dwell
      lit("f0_d0a", 1, 4'b1110, 7'h3F, 1'b0);
      lit("f0_d0b", 4, 4'b1110, 7'h3F, 1'b0);
      lit("f0_d1",  5, 4'b1101, 7'h3F, 1'b0);
      goto(9);  check("f0_d2_dig", 32'(bus.dig), 32'hB);
      goto(13); check("f0_d3_dig", 32'(bus.dig), 32'h7);
      goto(16); check("f0_d3_end", 32'(bus.dig), 32'h7);

      // Frame captured at edge 16: 12:34 with colon
      lit("t2_d0", 17, 4'b1110, 7'h66, 1'b0);
      lit("t2_d1", 21, 4'b1101, 7'h4F, 1'b0);
      lit("t2_d2", 25, 4'b1011, 7'h5B, 1'b1);
      lit("t2_d3", 29, 4'b0111, 7'h06, 1'b0);

      bus.q_hi = 7'h05;
      bus.blank_lz = 1'b1;
      lit("t3_d0", 33, 4'b1110, 7'h66, 1'b0);
      lit("t3_d2", 41, 4'b1011, 7'h6D, 1'b1);
      lit("t3_d3", 45, 4'b0111, 7'h00, 1'b0);

      bus.q_hi = 7'h00;
      bus.q_lo = 7'h00;
      lit("t3z_d0", 49, 4'b1110, 7'h3F, 1'b0);
      lit("t3z_d2", 57, 4'b1011, 7'h00, 1'b1);
      lit("t3z_d3", 61, 4'b0111, 7'h00, 1'b0);

      bus.q_lo = 7'h6A;
      lit("t4_d0", 65, 4'b1110, 7'h40, 1'b0);
      lit("t4_d1", 69, 4'b1101, 7'h40, 1'b0);
      lit("t4_d2", 73, 4'b1011, 7'h00, 1'b1);
      lit("t4_d3", 77, 4'b0111, 7'h00, 1'b0);

      // Seconds counting 00..59 every 3 cycles, minutes fixed
      ones = 4'd0;
      tens = 3'd0;
      bus.q_hi = 7'h07;
      for (int i = 0; i < 210; i++) begin
         if (i % 3 == 0) begin
            if (ones == 4'd9) begin
               ones = 4'd0;
               tens = (tens == 3'd5) ? 3'd0 : tens + 3'd1;
            end else begin
               ones = ones + 4'd1;
            end
            bus.q_lo = {tens, ones};
            if (i % 21 == 0) bus.colon = ~bus.colon;
         end
         goto(t + 1);
      end

      // Random inputs, mostly valid BCD, random option changes
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 5) == 0) begin
               bus.q_lo = 7'($urandom);
               bus.q_hi = 7'($urandom);
            end else begin
               bus.q_lo = {3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
               bus.q_hi = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 9))
                        : {3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            end
         end
         if ($urandom_range(0, 15) == 0) bus.blank_lz = 1'($urandom);
         if ($urandom_range(0, 7) == 0) bus.colon = 1'($urandom);
         goto(t + 1);
      end

      // Reset while digit 2 is displayed
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.dig == 4'b1011) found = 1'b1;
      end
      check("wait_idx2", 32'(found), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("arst_dig", 32'(bus.dig), 32'hF);
      check("arst_seg", 32'(bus.seg), 32'h0);
      check("arst_dp",  32'(bus.dp),  32'h0);
      bus.q_lo = 7'h59;
      bus.q_hi = 7'h42;
      @(negedge clk);
      #2 rst = 1'b1;
      t = 0;
      lit("r6_d0a", 1, 4'b1110, 7'h3F, 1'b0);
      lit("r6_d0b", 4, 4'b1110, 7'h3F, 1'b0);
      lit("r6_d1",  5, 4'b1101, 7'h3F, 1'b0);
      lit("r6_nf",  17, 4'b1110, 7'h6F, 1'b0);
      goto(24);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/scan7seg.md
# scan7seg

Four-digit multiplexed 7-segment display driver for the mm:ss digital clock. Sits directly downstream of the two cascaded `cnt60` stages and takes their packed BCD `q` outputs: seconds on `q_lo`, minutes on `q_hi`. It snapshots both values once per scan frame so a digit cannot tear mid-frame. It then time-multiplexes one digit at a time onto shared segment lines, with leading-zero blanking and an invalid-BCD indicator.

## Interface
Parameters:
- `DIV`, default 1000: clock cycles each digit stays lit. Legal values are `DIV` ≥ 2.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset. One clock domain; reset is asynchronous and active-low.
- `q_lo`  input  7  seconds in BCD: [6:4] tens, [3:0] ones (a `cnt60` `q`).
- `q_hi`  input  7  minutes in BCD, same packing.
- `blank_lz`  input  1  1 = blank leading zeros on digits 3 and 2.
- `colon`  input  1  1 = light the decimal point on digit 2 (the mm:ss separator).
- `seg`  output  7  segment drive, active-high: bit0 = a … bit6 = g.
- `dp`  output  1  decimal point, active-high.
- `dig`  output  4  digit enables, active-low, one-hot; bit0 = rightmost digit.

## Operation
- **Prescaler `div_cnt`**
  - Counts 0 … `DIV`−1, then wraps to 0.
  - `tick` is asserted in the cycle where `div_cnt` == `DIV`−1.
- **Digit index `idx`** (2 bits)
  - Advances on every `tick`: 0→1→2→3→0.
- **Snapshot register `snap`** (14 bits, holds {`q_hi`,`q_lo`})
  - Loads only on a `tick` with `idx` == 3, i.e. at the edge where `idx` wraps to 0.
  - Holds its value otherwise.
- **Digit source**
  - Digit 0 = `snap_lo[3:0]`
  - Digit 1 = {0, `snap_lo[6:4]`}
  - Digit 2 = `snap_hi[3:0]`
  - Digit 3 = {0, `snap_hi[6:4]`}
- **Segment decode** (hex values for `seg`)
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- **Invalid BCD**
  - Applies when a ones digit is > 9 or a tens digit is > 5.
  - That digit shows '-' (`seg` = 40).
  - Invalid-BCD display takes priority over blanking.
- **Blanking** (active only when `blank_lz` = 1; blanked digit gives `seg` = 00)
  - Digit 3 is blanked when its value is 0.
  - Digit 2 is blanked when digits 3 and 2 are both 0.
  - Digits 1 and 0 are never blanked.
- **Decimal point**
  - `dp` = `colon` when `idx` == 2, else 0.
  - `colon` is sampled live and is not part of the snapshot.
- **Output registers**
  - Every clock: `dig` ← ~(1 << `idx`); `seg` and `dp` ← decode of the current `idx` and `snap`.
- **Reset behaviour**
  - `div_cnt` = 0, `idx` = 0, `snap` = 0.
  - `seg` = 00, `dp` = 0, `dig` = 1111 (all digits off).
  - `blank_lz`, `colon`, `q_lo` and `q_hi` have no effect while `rst` = 0.

## Timing
- **Reset**
  - Assertion clears all state immediately, without waiting for a clock edge.
  - First active edge after release: `dig` = 1110, `seg` = 3F (snap = 0, digit 0 is never blanked).
- **Output latency**
  - `seg`, `dig` and `dp` lag `idx` by exactly one clock.
  - The edge that advances `idx` is followed, one edge later, by `dig`/`seg` for the new digit.
- **Dwell time**
  - Each digit is lit for exactly `DIV` cycles; one frame = 4×`DIV` cycles.
  - No overlap: exactly one `dig` bit is 0 at any time after the first post-reset edge.
- **Snapshot capture**
  - The snapshot takes the `q_lo`/`q_hi` values present at the wrap edge.
  - Input changes at any other time appear only after the next wrap, so all four digits of a frame come from one snapshot.
  - Until the first wrap after reset, the display shows snap = 0.
- **Simultaneous events**
  - An input change in the same cycle as the wrap edge is captured, since the inputs are sampled at that edge.
- **Reset mid-frame**
  - Aborts the scan; after release, scanning restarts at digit 0 with a full `DIV` dwell.

## Test plan
With `DIV` = 4:
1. Hold `rst` = 0 for 15 ns, then release → `dig` = 1111 and `seg` = 00 during reset; first edge after release gives `dig` = 1110, `seg` = 3F; `dig` then steps 1101, 1011, 0111, each for exactly 4 cycles.
2. `q_hi` = 7'h12, `q_lo` = 7'h34, `blank_lz` = 0, `colon` = 1, held over the first wrap → the next frame shows:
   - digit 0 `seg` = 66 (4)
   - digit 1 `seg` = 4F (3)
   - digit 2 `seg` = 5B (2) with `dp` = 1
   - digit 3 `seg` = 06 (1)
   - `dp` = 0 on all other digits.
3. `q_hi` = 7'h05, `blank_lz` = 1 → digit 3 `seg` = 00 and digit 2 `seg` = 6D. With `q_hi` = 0 → digits 3 and 2 both `seg` = 00, and digit 0 still shows 3F for `q_lo` = 0.
4. `q_lo` = 7'h6A (tens 6, ones A) → digits 0 and 1 both show `seg` = 40; with `q_hi` = 7'h00 and `blank_lz` = 1, digits 3 and 2 stay blank.
5. Drive `cnt60`-style `q_lo` counting 00→59→00 at `ci` once every 3 cycles → within every frame, all four `seg` values match a single captured value (no tearing); `q_lo` changes mid-frame appear only in the next frame.
6. Pull `rst` low while `idx` = 2 → `dig` = 1111 and `seg` = 00 immediately; after release, scanning restarts at digit 0 with a 4-cycle dwell and shows snap = 0 until the next wrap.
